// File: rtl/h264_fifo_pkg.sv
// Shared types and helpers for the H.264 intra pipeline FIFOs.
package h264_fifo_pkg;

    // Occupancy state of a synchronous FIFO controller.
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } fifo_state_e;

    // Smallest r with 2**r >= depth; used to validate DEPTH against PTR_WIDTH.
    function automatic int clog2_depth(input int depth);
        int r;
        r = 0;
        while ((1 << r) < depth) begin
            r++;
        end
        return r;
    endfunction

endpackage : h264_fifo_pkg

// File: rtl/fifo_mem.sv
// Storage array for the H.264 FIFOs: one write port, one asynchronous
// (first-word-fall-through) read port addressed by the extended read pointer.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int PTR_WIDTH  = 3
) (
    input  logic                  wr_clk,
    input  logic                  rd_clk,
    input  logic                  wr_en,
    input  logic                  full_i,
    input  logic [PTR_WIDTH:0]    b_wptr_i,
    input  logic [PTR_WIDTH:0]    b_rptr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    localparam int DEPTH = 1 << PTR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Write the addressed entry; a write while full is ignored as a safety net.
    // NOTE: the array has no reset on purpose -- contents are only meaningful
    // behind the pointers, and a reset would turn the RAM into a flop bank.
    always_ff @(posedge wr_clk) begin
        if (wr_en && !full_i) begin
            mem_q[b_wptr_i[PTR_WIDTH-1:0]] <= wr_data_i;
        end
    end

    // Head entry is presented without a read clock edge.
    assign rd_data_o = mem_q[b_rptr_i[PTR_WIDTH-1:0]];

    // The read side is combinational and the pointer wrap bits only matter to the
    // controller, so these inputs are intentionally consumed here.
    logic unused_mem_inputs;
    assign unused_mem_inputs = ^{rd_clk, b_wptr_i[PTR_WIDTH], b_rptr_i[PTR_WIDTH]};

endmodule : fifo_mem

// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO controller: extended binary pointers, EMPTY/PARTIAL/FULL
// occupancy FSM, registered fill count and almost flags around fifo_mem.
// Optional sticky overflow/underflow status: define FIFO_SYNC_CTRL_STATUS_EN.
module fifo_sync_ctrl
    import h264_fifo_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int PTR_WIDTH  = 3,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic [PTR_WIDTH:0]    count_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int CW = PTR_WIDTH + 1;
    localparam logic [PTR_WIDTH:0] CNT_ONE     = CW'(1);
    localparam logic [PTR_WIDTH:0] CNT_LAST    = CW'(DEPTH - 1);
    localparam logic [PTR_WIDTH:0] AF_LEVEL    = CW'(AF_THRESH);
    localparam logic [PTR_WIDTH:0] AE_LEVEL    = CW'(AE_THRESH);

    // Elaboration-time parameter sanity.
    if ((1 << PTR_WIDTH) != DEPTH || clog2_depth(DEPTH) != PTR_WIDTH) begin : g_bad_depth
        $error("fifo_sync_ctrl: DEPTH must equal 2**PTR_WIDTH");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("fifo_sync_ctrl: AF_THRESH out of range 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("fifo_sync_ctrl: AE_THRESH out of range 0..DEPTH-1");
    end

    fifo_state_e        state_q, state_d;
    logic [PTR_WIDTH:0] wptr_q, wptr_d;
    logic [PTR_WIDTH:0] rptr_q, rptr_d;
    logic [PTR_WIDTH:0] count_q, count_d;
    logic               push, pop;

    // Handshake flags decode only from the registered FSM state.
    assign wr_ready_o = (state_q != FULL);
    assign rd_valid_o = (state_q != EMPTY);
    assign push       = wr_valid_i & wr_ready_o;
    assign pop        = rd_valid_o & rd_ready_i;

    // Next pointers, count and occupancy state; flush overrides any traffic.
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            state_d = EMPTY;
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + 1'b1;
            if (pop)  rptr_d = rptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
            unique case (state_q)
                EMPTY:   if (push) state_d = PARTIAL;
                PARTIAL: begin
                    if (push && !pop && count_q == CNT_LAST)    state_d = FULL;
                    else if (pop && !push && count_q == CNT_ONE) state_d = EMPTY;
                end
                FULL:    if (pop) state_d = PARTIAL;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Controller state register with synchronous reset.
    // NOTE: sequential state uses <= so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign count_o        = count_q;
    assign almost_full_o  = (count_q >= AF_LEVEL);
    assign almost_empty_o = (count_q <= AE_LEVEL);

`ifdef FIFO_SYNC_CTRL_STATUS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error flags, cleared only by flush (or reset).
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush_i) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_valid_i && !wr_ready_o) overflow_d  = 1'b1;
            if (rd_ready_i && !rd_valid_o) underflow_d = 1'b1;
        end
    end

    // Status register.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
`else
    assign overflow_o  = 1'b0;
    assign underflow_o = 1'b0;
`endif

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .PTR_WIDTH  (PTR_WIDTH)
    ) u_mem (
        .wr_clk    (clk),
        .rd_clk    (clk),
        .wr_en     (push),
        .full_i    (!wr_ready_o),
        .b_wptr_i  (wptr_q),
        .b_rptr_i  (rptr_q),
        .wr_data_i (wr_data_i),
        .rd_data_o (rd_data_o)
    );

    // FSM must agree with the pointers, and the count with their distance.
    a_full_matches_ptrs: assert property (@(posedge clk) disable iff (rst)
        (state_q == FULL) == ((wptr_q[PTR_WIDTH] != rptr_q[PTR_WIDTH]) &&
                              (wptr_q[PTR_WIDTH-1:0] == rptr_q[PTR_WIDTH-1:0])));
    a_empty_matches_ptrs: assert property (@(posedge clk) disable iff (rst)
        (state_q == EMPTY) == (wptr_q == rptr_q));
    a_count_matches_ptrs: assert property (@(posedge clk) disable iff (rst)
        count_q == CW'(wptr_q - rptr_q));

endmodule : fifo_sync_ctrl

// File: tb/tb_fifo_sync_ctrl.sv
// Scoreboard bench for fifo_sync_ctrl: directed scenarios then random traffic,
// checked against a queue-based occupancy model.
module tb_fifo_sync_ctrl;

    localparam int DEPTH = 8;
    localparam int DW    = 8;
    localparam int PW    = 3;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush_i = 1'b0;
    logic          wr_valid_i = 1'b0;
    logic          wr_ready_o;
    logic [DW-1:0] wr_data_i = '0;
    logic          rd_valid_o;
    logic          rd_ready_i = 1'b0;
    logic [DW-1:0] rd_data_o;
    logic [PW:0]   count_o;
    logic          almost_full_o;
    logic          almost_empty_o;
    logic          overflow_o;
    logic          underflow_o;

    always #5 clk = ~clk;

    fifo_sync_ctrl #(
        .DEPTH(DEPTH), .DATA_WIDTH(DW), .PTR_WIDTH(PW), .AF_THRESH(AF), .AE_THRESH(AE)
    ) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_data_i(wr_data_i),
        .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o),
        .count_o(count_o), .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o),
        .overflow_o(overflow_o), .underflow_o(underflow_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: contents in order, occupancy, sticky status.
    logic [DW-1:0] exp_q [$];
    int occ   = 0;
    bit m_ov  = 1'b0;
    bit m_uf  = 1'b0;
    // Expectations for the current cycle (state before the coming edge).
    int e_occ = 0;
    bit e_ov  = 1'b0;
    bit e_uf  = 1'b0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: drive inputs, publish expectations, advance the model.
    task automatic step(input bit wv, input logic [DW-1:0] wd, input bit rr,
                        input bit fl, input bit r);
        bit do_push;
        bit do_pop;
        wr_valid_i = wv;
        wr_data_i  = wd;
        rd_ready_i = rr;
        flush_i    = fl;
        rst        = r;
        e_occ = occ;
        e_ov  = m_ov;
        e_uf  = m_uf;
        if (r || fl) begin
            exp_q.delete();
            occ  = 0;
            m_ov = 1'b0;
            m_uf = 1'b0;
        end else begin
            do_push = wv && (occ < DEPTH);
            do_pop  = rr && (occ > 0);
            if (wv && occ == DEPTH) m_ov = 1'b1;
            if (rr && occ == 0)     m_uf = 1'b1;
            if (do_push) exp_q.push_back(wd);
            occ = occ + int'(do_push) - int'(do_pop);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: flag checks every cycle; data check whenever the DUT hands a word out.
    always @(negedge clk) begin
        if (chk_en) begin
            check("wr_ready",     32'(wr_ready_o),     32'(e_occ < DEPTH));
            check("rd_valid",     32'(rd_valid_o),     32'(e_occ > 0));
            check("count",        32'(count_o),        32'(e_occ));
            check("almost_full",  32'(almost_full_o),  32'(e_occ >= AF));
            check("almost_empty", 32'(almost_empty_o), 32'(e_occ <= AE));
`ifdef FIFO_SYNC_CTRL_STATUS_EN
            check("overflow",     32'(overflow_o),     32'(e_ov));
            check("underflow",    32'(underflow_o),    32'(e_uf));
`else
            check("overflow",     32'(overflow_o),     32'(0));
            check("underflow",    32'(underflow_o),    32'(0));
`endif
            if (rd_valid_o && rd_ready_i && !flush_i && !rst) begin
                if (exp_q.size() == 0) begin
                    check("pop_while_model_empty", 32'(1), 32'(0));
                end else begin
                    check("rd_data", 32'(rd_data_o), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        int wbias;
        int rbias;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;

        // Reset mid-stream discards entries; reset dominates a concurrent write.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b1);
        step(1'b1, 8'hEF, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Fill to full, then drain in order.
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        idle(2);
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(2);

        // Prefill 4, then simultaneous push+pop across pointer wrap.
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h50 + i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(1);

        // Flush at count 5 with both sides active; the flushed-cycle word must never appear.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b1, 1'b1, 1'b0);
        idle(1);
        step(1'b1, 8'h71, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h72, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(1);

        // Status: write while full, hold, flush; then read while empty.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
        idle(3);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle(1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(3);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle(1);

        // Random traffic with shifting valid/ready bias and occasional flush/reset.
        wbias = 50;
        rbias = 50;
        for (int c = 0; c < 10000; c++) begin
            if (c % 250 == 0) begin
                wbias = int'($urandom_range(15, 90));
                rbias = int'($urandom_range(15, 90));
            end
            step(int'($urandom_range(0, 99)) < wbias, 8'($urandom),
                 int'($urandom_range(0, 99)) < rbias,
                 $urandom_range(0, 399) == 0, $urandom_range(0, 1999) == 0);
        end
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(1);
        check("final_model_empty", 32'(exp_q.size()), 32'(0));

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fifo_sync_ctrl
